qspi_wr_buffer: RTL and testbench

- Write-path buffer between the AHB slave datapath and the QSPI shift engine for indirect-mode flash writes.
- Accepts 32-bit words pushed by each TX_DATA register write (0x14) into a word FIFO.
- Unpacks the words into a byte stream with a valid/ready handshake, emitting exactly the programmed byte count, then pulses done.

---
 rtl/qspi_pkg.sv | 15 +
 rtl/qspi_wr_buffer_if.sv | 34 +++
 rtl/qspi_word_fifo.sv | 83 ++++++++
 rtl/qspi_wr_buffer.sv | 131 +++++++++++++
 tb/tb_qspi_wr_buffer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI indirect-write buffer.
package qspi_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } wrbuf_state_e;

endpackage

// File: rtl/qspi_wr_buffer_if.sv
// Bus bundle between the AHB-side register block / shift engine and the write buffer.
interface qspi_wr_buffer_if
  import qspi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic              wr_en;
  logic [WORD_W-1:0] wr_data;
  logic              flush;
  logic              start;
  logic [7:0]        num_bytes;
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;
  logic              full;
  logic              empty;
  logic [AW:0]       word_count;
  logic              overflow;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_data, flush, start, num_bytes, byte_ready,
    input  byte_data, byte_valid, full, empty, word_count, overflow, busy, done
  );

  modport slave (
    input  wr_en, wr_data, flush, start, num_bytes, byte_ready,
    output byte_data, byte_valid, full, empty, word_count, overflow, busy, done
  );

endinterface

// File: rtl/qspi_word_fifo.sv
// Synchronous word FIFO with registered count/full/empty and a sticky overflow flag.
module qspi_word_fifo
  import qspi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     h_clk,
  input  logic                     h_rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              push_ok_c;
  logic              pop_ok_c;

  // A pop never makes room for a push in the same cycle: full gates the push
  always_comb begin
    push_ok_c = push && !full_q && !flush;
    pop_ok_c  = pop && !empty_q && !flush;
    count_nxt = count_q;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push_ok_c, pop_ok_c})
        2'b10:   count_nxt = count_q + (AW+1)'(1);
        2'b01:   count_nxt = count_q - (AW+1)'(1);
        default: count_nxt = count_q;
      endcase
    end
  end

  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && full_q) overflow_q <= 1'b1;
      end
      count_q <= count_nxt;
      full_q  <= (count_nxt == (AW+1)'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge h_clk) begin
    if (push_ok_c) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data_c = mem[rd_ptr_q];
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/qspi_wr_buffer.sv
// Indirect-write buffer: word FIFO feeding a little-endian byte unpacker with valid/ready.
module qspi_wr_buffer
  import qspi_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic           h_clk,
  input  logic           h_rst,
  qspi_wr_buffer_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD);

  wrbuf_state_e      state_q;
  wrbuf_state_e      state_nxt;
  logic [WORD_W-1:0] shreg_q;
  logic [WORD_W-1:0] shreg_nxt;
  logic [7:0]        rem_q;
  logic [7:0]        rem_nxt;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_nxt;
  logic              pop_c;
  logic              fire_c;
  logic [WORD_W-1:0] fifo_rd_data_c;
  logic              fifo_empty;
  logic [BYTE_W-1:0] byte_data_q;
  logic              byte_valid_q;
  logic              busy_q;
  logic              done_q;

  qspi_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .h_clk     (h_clk),
    .h_rst     (h_rst),
    .flush     (bus.flush),
    .push      (bus.wr_en),
    .wr_data   (bus.wr_data),
    .pop       (pop_c),
    .rd_data_c (fifo_rd_data_c),
    .full      (bus.full),
    .empty     (fifo_empty),
    .count     (bus.word_count),
    .overflow  (bus.overflow)
  );

  assign fire_c = (state_q == SEND) && bus.byte_ready;

  // State register
  always_ff @(posedge h_clk) begin
    if (h_rst) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // Next-state logic; flush aborts without passing through DONE
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_nxt = (bus.num_bytes != '0) ? FETCH : DONE;
      FETCH: if (!fifo_empty) state_nxt = SEND;
      SEND: begin
        if (fire_c) begin
          if (rem_q == 8'd1)                              state_nxt = DONE;
          else if (idx_q == IDX_W'(BYTES_PER_WORD - 1))   state_nxt = FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // Datapath and output next-values
  always_comb begin
    shreg_nxt = shreg_q;
    rem_nxt   = rem_q;
    idx_nxt   = idx_q;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && (bus.num_bytes != '0)) begin
          rem_nxt = bus.num_bytes;
          idx_nxt = '0;
        end
      end
      FETCH: begin
        if (!fifo_empty) begin
          pop_c     = 1'b1;
          shreg_nxt = fifo_rd_data_c;
        end
      end
      SEND: begin
        if (fire_c) begin
          shreg_nxt = shreg_q >> BYTE_W;
          rem_nxt   = rem_q - 8'd1;
          idx_nxt   = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
    if (bus.flush) pop_c = 1'b0;
  end

  // Registered outputs track the state being entered so they align with it
  always_ff @(posedge h_clk) begin
    if (h_rst) begin
      shreg_q      <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      shreg_q      <= shreg_nxt;
      rem_q        <= rem_nxt;
      idx_q        <= idx_nxt;
      byte_data_q  <= shreg_nxt[BYTE_W-1:0];
      byte_valid_q <= (state_nxt == SEND);
      busy_q       <= (state_nxt != IDLE);
      done_q       <= (state_nxt == DONE);
    end
  end

  assign bus.empty      = fifo_empty;
  assign bus.byte_data  = byte_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_qspi_wr_buffer.sv
// Directed self-checking bench for qspi_wr_buffer.
module tb_qspi_wr_buffer;

  logic h_clk;
  logic h_rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  qspi_wr_buffer_if #(.DEPTH(8)) bus ();

  qspi_wr_buffer #(.DEPTH(8)) dut (
    .h_clk (h_clk),
    .h_rst (h_rst),
    .bus   (bus)
  );

  initial h_clk = 1'b0;
  always #5 h_clk = ~h_clk;

  task automatic step();
    @(posedge h_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] n);
    bus.start     = 1'b1;
    bus.num_bytes = n;
    step();
    bus.start     = 1'b0;
  endtask

  // Waits (bounded) for a valid byte, checks it, and lets it be consumed
  task automatic recv_byte(input string tag, input logic [7:0] exp);
    int k = 0;
    while (!bus.byte_valid && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_valid"}, 32'(bus.byte_valid), 32'd1);
    chk(tag, 32'(bus.byte_data), 32'(exp));
    step();
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (!bus.done && k < 40) begin
      step();
      k++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    step();
    chk({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    h_rst          = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_data    = '0;
    bus.flush      = 1'b0;
    bus.start      = 1'b0;
    bus.num_bytes  = '0;
    bus.byte_ready = 1'b1;
    step();
    step();
    h_rst = 1'b0;

    chk("rst_byte_data", 32'(bus.byte_data), 32'd0);
    chk("rst_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_count", 32'(bus.word_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);

    // Two words, eight bytes, little-endian
    push(32'h44332211);
    push(32'h88776655);
    chk("t1_count", 32'(bus.word_count), 32'd2);
    start_xfer(8'd8);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    recv_byte("t1_b0", 8'h11);
    recv_byte("t1_b1", 8'h22);
    recv_byte("t1_b2", 8'h33);
    recv_byte("t1_b3", 8'h44);
    recv_byte("t1_b4", 8'h55);
    recv_byte("t1_b5", 8'h66);
    recv_byte("t1_b6", 8'h77);
    recv_byte("t1_b7", 8'h88);
    wait_done("t1");
    chk("t1_count_end", 32'(bus.word_count), 32'd0);

    // Partial word: top byte discarded
    push(32'hDDCCBBAA);
    start_xfer(8'd3);
    recv_byte("t2_b0", 8'hAA);
    recv_byte("t2_b1", 8'hBB);
    recv_byte("t2_b2", 8'hCC);
    wait_done("t2");
    chk("t2_empty", 32'(bus.empty), 32'd1);

    // Overflow: ninth push dropped
    for (int i = 0; i < 9; i++) push({8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'hD0 + 8'(i)});
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_count", 32'(bus.word_count), 32'd8);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    start_xfer(8'd32);
    for (int i = 0; i < 8; i++) begin
      recv_byte($sformatf("t3_w%0d_b0", i), 8'hD0 + 8'(i));
      recv_byte($sformatf("t3_w%0d_b1", i), 8'hC0 + 8'(i));
      recv_byte($sformatf("t3_w%0d_b2", i), 8'hB0 + 8'(i));
      recv_byte($sformatf("t3_w%0d_b3", i), 8'hA0 + 8'(i));
    end
    wait_done("t3");
    chk("t3_drained_empty", 32'(bus.empty), 32'd1);
    chk("t3_ovf_sticky", 32'(bus.overflow), 32'd1);
    push(32'h12345678);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t3_flush_count", 32'(bus.word_count), 32'd0);
    chk("t3_flush_ovf", 32'(bus.overflow), 32'd0);
    chk("t3_flush_empty", 32'(bus.empty), 32'd1);

    // Underrun stall, then data arrives
    start_xfer(8'd4);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t4_stall_busy%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("t4_stall_valid%0d", i), 32'(bus.byte_valid), 32'd0);
      step();
    end
    push(32'h04030201);
    recv_byte("t4_b0", 8'h01);
    recv_byte("t4_b1", 8'h02);
    recv_byte("t4_b2", 8'h03);
    recv_byte("t4_b3", 8'h04);
    wait_done("t4");

    // Backpressure holds the first byte stable
    push(32'hA5A5A55A);
    bus.byte_ready = 1'b0;
    start_xfer(8'd4);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t5_hold_valid%0d", i), 32'(bus.byte_valid), 32'd1);
      chk($sformatf("t5_hold_data%0d", i), 32'(bus.byte_data), 32'h5A);
      step();
    end
    bus.byte_ready = 1'b1;
    recv_byte("t5_b0", 8'h5A);
    recv_byte("t5_b1", 8'hA5);
    recv_byte("t5_b2", 8'hA5);
    recv_byte("t5_b3", 8'hA5);
    wait_done("t5");

    // Flush mid-transfer, then a zero-length transfer
    push(32'h44332211);
    push(32'h88776655);
    start_xfer(8'd6);
    recv_byte("t6_b0", 8'h11);
    recv_byte("t6_b1", 8'h22);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("t6_flush_valid", 32'(bus.byte_valid), 32'd0);
    chk("t6_flush_busy", 32'(bus.busy), 32'd0);
    chk("t6_flush_done", 32'(bus.done), 32'd0);
    chk("t6_flush_count", 32'(bus.word_count), 32'd0);
    step();
    chk("t6_no_done", 32'(bus.done), 32'd0);
    chk("t6_idle_valid", 32'(bus.byte_valid), 32'd0);
    start_xfer(8'd0);
    chk("t6_zero_done", 32'(bus.done), 32'd1);
    chk("t6_zero_valid", 32'(bus.byte_valid), 32'd0);
    chk("t6_zero_busy", 32'(bus.busy), 32'd1);
    step();
    chk("t6_zero_done_drop", 32'(bus.done), 32'd0);
    chk("t6_zero_valid2", 32'(bus.byte_valid), 32'd0);
    chk("t6_zero_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
